// File: rtl/gobou_pkg.sv
// gobou_pkg: shared FSM encodings and default widths for the gobou write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gobou_pkg;

  localparam int DWIDTH_DEF  = 16;
  localparam int MEMSIZE_DEF = 12;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_ACTIVE = 2'd1,
    WB_DRAIN  = 2'd2,
    WB_DONE   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/gobou_wb_fifo.sv
// gobou_wb_fifo: synchronous FIFO buffering ReLU words ahead of the memory write port.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk/xrst (sync, active-high); push+wdata write side; pop+rdata read side
//        (rdata is the current head); full/empty status flags.
module gobou_wb_fifo #(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pop,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DWIDTH-1:0] store [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Full is judged before any same-edge pop, so a push into a full FIFO is lost.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (xrst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gobou_ctrl_wb.sv
// gobou_ctrl_wb: write-back controller; buffers framed ReLU words and writes them sequentially to memory.
// Latency: in_valid at cycle t -> mem_we at t+2; last word at t -> done at t+3.
// Backpressure: mem_ready low stalls pops; words arriving while the FIFO is full are dropped and flag err.
// Ports: clk/xrst (sync, active-high); in_begin/in_valid/in_end/in_data framed input;
//        out_base/out_size latched at frame start; mem_ready grant; mem_we/mem_addr/mem_wdata
//        write port; busy/done/err status to the host side.
module gobou_ctrl_wb
  import gobou_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int MEMSIZE    = MEMSIZE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               in_begin,
  input  logic               in_valid,
  input  logic               in_end,
  input  logic [DWIDTH-1:0]  in_data,
  input  logic [MEMSIZE-1:0] out_base,
  input  logic [MEMSIZE-1:0] out_size,
  input  logic               mem_ready,
  output logic               mem_we,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [DWIDTH-1:0]  mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  wb_state_t          state;
  wb_state_t          state_nx;
  logic [MEMSIZE-1:0] base_r;
  logic [MEMSIZE-1:0] size_r;
  logic [MEMSIZE-1:0] wr_count;
  logic [MEMSIZE-1:0] rx_count;
  logic [MEMSIZE-1:0] size_eff;
  logic [MEMSIZE-1:0] rx_eff;
  logic [DWIDTH-1:0]  fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               begin_acc;
  logic               take;
  logic               excess;
  logic               overflow;
  logic               push;
  logic               pop;
  logic               short_frame;

  // A word arriving with the accepted in_begin is word 0 of the new frame, so
  // the limit and counter it is checked against are the fresh ones.
  assign begin_acc   = (state == WB_IDLE) && in_begin;
  assign take        = in_valid && ((state == WB_ACTIVE) || begin_acc);
  assign size_eff    = begin_acc ? out_size : size_r;
  assign rx_eff      = begin_acc ? '0 : rx_count;
  assign excess      = take && (rx_eff == size_eff);
  assign overflow    = take && !excess && fifo_full;
  assign push        = take && !excess && !fifo_full;
  assign pop         = !fifo_empty && mem_ready;
  assign short_frame = (state == WB_DRAIN) && (state_nx == WB_DONE) && (wr_count != size_r);

  gobou_wb_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .xrst  (xrst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (xrst) state <= WB_IDLE;
    else      state <= state_nx;
  end

  // A pop issues its write on the same edge, so an empty FIFO in DRAIN also
  // means no write is outstanding.
  always_comb begin
    state_nx = state;
    case (state)
      WB_IDLE:   if (in_begin)   state_nx = WB_ACTIVE;
      WB_ACTIVE: if (in_end)     state_nx = WB_DRAIN;
      WB_DRAIN:  if (fifo_empty) state_nx = WB_DONE;
      WB_DONE:                   state_nx = WB_IDLE;
      default:                   state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      base_r    <= '0;
      size_r    <= '0;
      wr_count  <= '0;
      rx_count  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= pop;
      if (pop) begin
        mem_addr  <= base_r + wr_count;
        mem_wdata <= fifo_head;
        wr_count  <= wr_count + 1'b1;
      end
      if (begin_acc) begin
        base_r   <= out_base;
        size_r   <= out_size;
        wr_count <= '0;
      end
      if (push)           rx_count <= rx_eff + 1'b1;
      else if (begin_acc) rx_count <= '0;
      err  <= (begin_acc ? 1'b0 : err) | excess | overflow | short_frame;
      done <= (state_nx == WB_DONE);
      busy <= (state_nx != WB_IDLE);
    end
  end

endmodule
